// File: rtl/mac_seq_if.sv
// Bundle of the command, operand, MAC-drive and result signals of the
// MAC sequencer. The slave view belongs to the sequencer; the master view
// belongs to whatever issues jobs, feeds operands, models the MAC and
// consumes results.
interface mac_seq_if;
    // Job request
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_mode;
    logic [7:0]  cmd_len;
    logic        cmd_sat;
    // Operand stream
    logic        op_valid;
    logic        op_ready;
    logic [15:0] op_a;
    logic [15:0] op_b;
    // MAC drive and feedback
    logic [2:0]  mac_instruction;
    logic [15:0] mac_multiplier;
    logic [15:0] mac_multiplicand;
    logic        mac_stall;
    logic [31:0] mac_result;
    logic [7:0]  mac_protect;
    // Result handshake and status
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic [7:0]  res_guard;
    logic        busy;

    modport slave (
        input  cmd_valid, cmd_mode, cmd_len, cmd_sat,
        input  op_valid, op_a, op_b,
        input  mac_result, mac_protect,
        input  res_ready,
        output cmd_ready, op_ready,
        output mac_instruction, mac_multiplier, mac_multiplicand, mac_stall,
        output res_valid, res_data, res_guard, busy
    );

    modport master (
        output cmd_valid, cmd_mode, cmd_len, cmd_sat,
        output op_valid, op_a, op_b,
        output mac_result, mac_protect,
        output res_ready,
        input  cmd_ready, op_ready,
        input  mac_instruction, mac_multiplier, mac_multiplicand, mac_stall,
        input  res_valid, res_data, res_guard, busy
    );
endinterface

// File: rtl/mac_seq.sv
// MAC job sequencer: accepts a job (mode, length, saturate), streams the
// operand pairs into a 3-edge-latency MAC as load/accumulate instructions,
// optionally saturates, drains the pipeline, captures the accumulator and
// hands it out on a valid/ready result port.
// Instruction encoding: bit 2 = dual 8x8 mode, bits 1:0 = 00 clear,
// 01 load, 10 accumulate, 11 saturate. Operand gaps are covered by stalling
// the MAC, never by inserting a clear.
module mac_seq (
    input  logic     clk,
    input  logic     reset,
    mac_seq_if.slave bus
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_SAT   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_CAPT  = 3'd4,
        ST_OUT   = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic        mode_q, mode_d;
    logic        sat_q, sat_d;
    logic [7:0]  len_q, len_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        drain_q, drain_d;
    logic [31:0] res_data_q, res_data_d;
    logic [7:0]  res_guard_q, res_guard_d;

    logic        cmd_ready_s;
    logic        op_ready_s;
    logic [2:0]  mac_instr_s;
    logic [15:0] mac_mult_s;
    logic [15:0] mac_mcand_s;
    logic        mac_stall_s;
    logic        res_valid_s;
    logic        busy_s;

    // State and job-context registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            mode_q      <= 1'b0;
            sat_q       <= 1'b0;
            len_q       <= 8'd0;
            cnt_q       <= 8'd0;
            drain_q     <= 1'b0;
            res_data_q  <= 32'd0;
            res_guard_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            sat_q       <= sat_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            drain_q     <= drain_d;
            res_data_q  <= res_data_d;
            res_guard_q <= res_guard_d;
        end
    end

    // Next-state logic and state-decoded MAC / handshake outputs.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        sat_d       = sat_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        drain_d     = drain_q;
        res_data_d  = res_data_q;
        res_guard_d = res_guard_q;

        cmd_ready_s = 1'b0;
        op_ready_s  = 1'b0;
        mac_instr_s = 3'b000;
        mac_mult_s  = 16'h0000;
        mac_mcand_s = 16'h0000;
        mac_stall_s = 1'b1;
        res_valid_s = 1'b0;
        busy_s      = 1'b1;

        case (state_q)
            ST_IDLE: begin
                cmd_ready_s = 1'b1;
                busy_s      = 1'b0;
                if (bus.cmd_valid) begin
                    mode_d  = bus.cmd_mode;
                    len_d   = bus.cmd_len;
                    sat_d   = bus.cmd_sat;
                    cnt_d   = 8'd0;
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_ISSUE: begin
                if (len_q == 8'd0) begin
                    // Empty job: one clear so the captured result reads zero.
                    mac_instr_s = {mode_q, 2'b00};
                    mac_stall_s = 1'b0;
                    drain_d     = 1'b0;
                    state_d     = sat_q ? ST_SAT : ST_DRAIN;
                end else begin
                    op_ready_s  = 1'b1;
                    mac_stall_s = ~bus.op_valid;
                    mac_mult_s  = bus.op_a;
                    mac_mcand_s = bus.op_b;
                    if (cnt_q == 8'd0) begin
                        mac_instr_s = {mode_q, 2'b01};
                    end else begin
                        mac_instr_s = {mode_q, 2'b10};
                    end
                    if (bus.op_valid) begin
                        cnt_d = cnt_q + 8'd1;
                        if ((cnt_q + 8'd1) == len_q) begin
                            drain_d = 1'b0;
                            state_d = sat_q ? ST_SAT : ST_DRAIN;
                        end else begin
                            state_d = ST_ISSUE;
                        end
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end

            ST_SAT: begin
                mac_instr_s = {mode_q, 2'b11};
                mac_stall_s = 1'b0;
                drain_d     = 1'b0;
                state_d     = ST_DRAIN;
            end

            ST_DRAIN: begin
                // Two unstalled edges push the last instruction out of the MAC.
                mac_stall_s = 1'b0;
                if (drain_q) begin
                    drain_d = 1'b0;
                    state_d = ST_CAPT;
                end else begin
                    drain_d = 1'b1;
                    state_d = ST_DRAIN;
                end
            end

            ST_CAPT: begin
                res_data_d  = bus.mac_result;
                res_guard_d = bus.mac_protect;
                state_d     = ST_OUT;
            end

            ST_OUT: begin
                res_valid_s = 1'b1;
                if (bus.res_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_OUT;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.cmd_ready        = cmd_ready_s;
    assign bus.op_ready         = op_ready_s;
    assign bus.mac_instruction  = mac_instr_s;
    assign bus.mac_multiplier   = mac_mult_s;
    assign bus.mac_multiplicand = mac_mcand_s;
    assign bus.mac_stall        = mac_stall_s;
    assign bus.res_valid        = res_valid_s;
    assign bus.res_data         = res_data_q;
    assign bus.res_guard        = res_guard_q;
    assign bus.busy             = busy_s;

endmodule

// File: tb/tb_mac_seq.sv
// Bench for mac_seq: a cycle-level MAC model (3 unstalled edges of latency)
// sits on the MAC side; results are predicted from the operand list with
// plain sum-of-products arithmetic and saturation clamping.
module tb_mac_seq;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mac_seq_if bus ();

    mac_seq dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [15:0] pa [256];
    logic [15:0] pb [256];

    // ------------------------------------------------------------------
    // MAC model: 3-deep pipeline, advances only on unstalled edges.
    // Keeps a 40-bit accumulator and two 20-bit lane accumulators.
    // ------------------------------------------------------------------
    logic [2:0]  p1_ins = 3'b000, p2_ins = 3'b000;
    logic [15:0] p1_a = 16'h0, p1_b = 16'h0, p2_a = 16'h0, p2_b = 16'h0;
    logic signed [39:0] m_acc = 40'sh0;
    logic signed [19:0] m_lo = 20'sh0, m_hi = 20'sh0;
    logic        m_dual = 1'b0;

    logic signed [31:0] m_p32;
    logic signed [15:0] m_plo, m_phi;
    logic signed [39:0] m_prod, m_acc_sat;
    logic signed [19:0] m_elo, m_ehi, m_lo_sat, m_hi_sat;

    assign m_p32  = $signed(p2_a) * $signed(p2_b);
    assign m_plo  = $signed(p2_a[7:0]) * $signed(p2_b[7:0]);
    assign m_phi  = $signed(p2_a[15:8]) * $signed(p2_b[15:8]);
    assign m_prod = {{8{m_p32[31]}}, m_p32};
    assign m_elo  = {{4{m_plo[15]}}, m_plo};
    assign m_ehi  = {{4{m_phi[15]}}, m_phi};
    assign m_acc_sat = (m_acc > 40'sh007FFFFFFF) ? 40'sh007FFFFFFF :
                       (m_acc < 40'shFF80000000) ? 40'shFF80000000 : m_acc;
    assign m_lo_sat  = (m_lo > 20'sh07FFF) ? 20'sh07FFF :
                       (m_lo < 20'shF8000) ? 20'shF8000 : m_lo;
    assign m_hi_sat  = (m_hi > 20'sh07FFF) ? 20'sh07FFF :
                       (m_hi < 20'shF8000) ? 20'shF8000 : m_hi;

    assign bus.mac_result  = m_dual ? {m_hi[15:0], m_lo[15:0]} : m_acc[31:0];
    assign bus.mac_protect = m_dual ? {m_hi[19:16], m_lo[19:16]} : m_acc[39:32];

    // MAC pipeline model.
    always @(posedge clk) begin
        if (bus.mac_stall == 1'b0) begin
            case (p2_ins[1:0])
                2'b00: begin m_acc <= 40'sh0; m_lo <= 20'sh0; m_hi <= 20'sh0; end
                2'b01: begin m_acc <= m_prod; m_lo <= m_elo; m_hi <= m_ehi; end
                2'b10: begin m_acc <= m_acc + m_prod; m_lo <= m_lo + m_elo; m_hi <= m_hi + m_ehi; end
                default: begin m_acc <= m_acc_sat; m_lo <= m_lo_sat; m_hi <= m_hi_sat; end
            endcase
            m_dual <= p2_ins[2];
            p2_ins <= p1_ins;
            p2_a   <= p1_a;
            p2_b   <= p1_b;
            p1_ins <= bus.mac_instruction;
            p1_a   <= bus.mac_multiplier;
            p1_b   <= bus.mac_multiplicand;
        end
    end

    // ------------------------------------------------------------------
    // Reference: {guard, data} straight from the operand list.
    // ------------------------------------------------------------------
    function automatic logic [39:0] ref_result(input bit mode, input int len, input bit sat);
        longint s, lo, hi;
        int va, vb;
        logic [39:0] r;
        s = 64'sd0; lo = 64'sd0; hi = 64'sd0;
        for (int i = 0; i < len; i++) begin
            va = $signed(pa[i]);       vb = $signed(pb[i]);
            s  = s + longint'(va) * longint'(vb);
            va = $signed(pa[i][7:0]);  vb = $signed(pb[i][7:0]);
            lo = lo + longint'(va) * longint'(vb);
            va = $signed(pa[i][15:8]); vb = $signed(pb[i][15:8]);
            hi = hi + longint'(va) * longint'(vb);
        end
        if (sat) begin
            if (s > 64'sd2147483647) s = 64'sd2147483647;
            else if (s < -64'sd2147483648) s = -64'sd2147483648;
            else s = s;
            if (lo > 64'sd32767) lo = 64'sd32767;
            else if (lo < -64'sd32768) lo = -64'sd32768;
            else lo = lo;
            if (hi > 64'sd32767) hi = 64'sd32767;
            else if (hi < -64'sd32768) hi = -64'sd32768;
            else hi = hi;
        end
        if (mode) r = {hi[19:16], lo[19:16], hi[15:0], lo[15:0]};
        else      r = s[39:0];
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Stimulus drivers (called at a negedge, return at a negedge)
    // ------------------------------------------------------------------
    task automatic start_job(input bit mode, input logic [7:0] len, input bit sat, output bit to);
        int n;
        n = 0;
        while (bus.cmd_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        to = (n >= 50);
        bus.cmd_valid = 1'b1;
        bus.cmd_mode  = mode;
        bus.cmd_len   = len;
        bus.cmd_sat   = sat;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    // Streams pairs; counts cycles where stall/op_ready/instruction/operands misbehave.
    task automatic feed_ops(input bit mode, input int len, input int gap, output int bad);
        logic [2:0] exp_ins;
        bad = 0;
        for (int i = 0; i < len; i++) begin
            if (i > 0) begin
                for (int g = 0; g < gap; g++) begin
                    bus.op_valid = 1'b0;
                    #1;
                    if (bus.mac_stall !== 1'b1 || bus.op_ready !== 1'b1) bad++;
                    @(negedge clk);
                end
            end
            bus.op_valid = 1'b1;
            bus.op_a = pa[i];
            bus.op_b = pb[i];
            #1;
            exp_ins = {mode, (i == 0) ? 2'b01 : 2'b10};
            if (bus.mac_stall !== 1'b0 || bus.op_ready !== 1'b1 || bus.mac_instruction !== exp_ins ||
                bus.mac_multiplier !== pa[i] || bus.mac_multiplicand !== pb[i]) bad++;
            @(negedge clk);
        end
        bus.op_valid = 1'b0;
    endtask

    task automatic wait_res(output bit to);
        int n;
        n = 0;
        while (bus.res_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        to = (n >= 40);
    endtask

    task automatic accept_res();
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
    endtask

    task automatic load_basic();
        pa[0] = 16'd3;    pb[0] = 16'd4;
        pa[1] = 16'hFFFE; pb[1] = 16'd5;
        pa[2] = 16'd100;  pb[2] = 16'd100;
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b want 1", bus.cmd_ready); end
        checks++; if (bus.op_ready !== 1'b0) begin errors++; $display("FAIL reset_op_ready: got %b want 0", bus.op_ready); end
        checks++; if (bus.mac_stall !== 1'b1) begin errors++; $display("FAIL reset_stall: got %b want 1", bus.mac_stall); end
        checks++; if (bus.mac_instruction !== 3'b000) begin errors++; $display("FAIL reset_instr: got %b want 000", bus.mac_instruction); end
        checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid: got %b want 0", bus.res_valid); end
        checks++; if (bus.res_data !== 32'h0) begin errors++; $display("FAIL reset_res_data: got %h want 0", bus.res_data); end
        checks++; if (bus.res_guard !== 8'h0) begin errors++; $display("FAIL reset_res_guard: got %h want 0", bus.res_guard); end
        @(negedge clk);
    endtask

    task automatic test_basic();
        bit to1, to2; int bad;
        load_basic();
        start_job(1'b0, 8'd3, 1'b0, to1);
        feed_ops(1'b0, 3, 0, bad);
        wait_res(to2);
        checks++; if ({to1, to2} !== 2'b00) begin errors++; $display("FAIL basic_timeout: got %b want 00", {to1, to2}); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL basic_issue: got %0d bad cycles want 0", bad); end
        checks++; if (bus.res_data !== 32'h00002712) begin errors++; $display("FAIL basic_data: got %h want 00002712", bus.res_data); end
        checks++; if (bus.res_guard !== 8'h00) begin errors++; $display("FAIL basic_guard: got %h want 00", bus.res_guard); end
        accept_res();
        #1;
        checks++; if (bus.res_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL basic_handoff: got valid=%b ready=%b want 0 1", bus.res_valid, bus.cmd_ready); end
    endtask

    task automatic test_sat();
        bit to1, to2; int bad;
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 3; i++) begin pa[i] = 16'h7FFF; pb[i] = 16'h7FFF; end
            start_job(1'b0, 8'd3, s[0], to1);
            feed_ops(1'b0, 3, 0, bad);
            wait_res(to2);
            checks++; if ({to1, to2, bad != 0} !== 3'b000) begin errors++; $display("FAIL sat%0d_flow: got to=%b%b bad=%0d want 00 0", s, to1, to2, bad); end
            if (s == 0) begin
                checks++; if (bus.res_data !== 32'hBFFD0003 || bus.res_guard !== 8'h00) begin errors++; $display("FAIL sat0_result: got %h/%h want BFFD0003/00", bus.res_data, bus.res_guard); end
            end else begin
                checks++; if (bus.res_data !== 32'h7FFFFFFF) begin errors++; $display("FAIL sat1_data: got %h want 7FFFFFFF", bus.res_data); end
                checks++; if (bus.res_guard !== ref_result(1'b0, 3, 1'b1) >> 32) begin errors++; $display("FAIL sat1_guard: got %h want 00", bus.res_guard); end
            end
            accept_res();
        end
    endtask

    task automatic test_dual();
        bit to1, to2; int bad;
        for (int i = 0; i < 2; i++) begin pa[i] = 16'h0203; pb[i] = 16'h0405; end
        start_job(1'b1, 8'd2, 1'b0, to1);
        feed_ops(1'b1, 2, 0, bad);
        wait_res(to2);
        checks++; if ({to1, to2, bad != 0} !== 3'b000) begin errors++; $display("FAIL dual_flow: got to=%b%b bad=%0d want 00 0", to1, to2, bad); end
        checks++; if (bus.res_data !== 32'h0010001E || bus.res_guard !== 8'h00) begin errors++; $display("FAIL dual_result: got %h/%h want 0010001E/00", bus.res_data, bus.res_guard); end
        accept_res();
    endtask

    task automatic test_gap();
        bit to1, to2; int bad;
        load_basic();
        start_job(1'b0, 8'd3, 1'b0, to1);
        feed_ops(1'b0, 3, 2, bad);
        wait_res(to2);
        checks++; if ({to1, to2} !== 2'b00) begin errors++; $display("FAIL gap_timeout: got %b want 00", {to1, to2}); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL gap_stall: got %0d bad cycles want 0", bad); end
        checks++; if (bus.res_data !== 32'h00002712 || bus.res_guard !== 8'h00) begin errors++; $display("FAIL gap_result: got %h/%h want 00002712/00", bus.res_data, bus.res_guard); end
        accept_res();
    endtask

    task automatic test_hold();
        bit to1, to2; int bad; int held_bad;
        load_basic();
        start_job(1'b0, 8'd3, 1'b0, to1);
        feed_ops(1'b0, 3, 0, bad);
        wait_res(to2);
        held_bad = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_len   = 8'd1;
        for (int c = 0; c < 5; c++) begin
            #1;
            if (bus.res_valid !== 1'b1 || bus.res_data !== 32'h00002712 || bus.cmd_ready !== 1'b0 || bus.busy !== 1'b1) held_bad++;
            @(negedge clk);
        end
        bus.cmd_valid = 1'b0;
        checks++; if ({to1, to2, bad != 0} !== 3'b000) begin errors++; $display("FAIL hold_flow: got to=%b%b bad=%0d want 00 0", to1, to2, bad); end
        checks++; if (held_bad !== 0) begin errors++; $display("FAIL hold_stable: got %0d bad cycles want 0", held_bad); end
        accept_res();
        #1;
        checks++; if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL hold_handoff: got valid=%b busy=%b ready=%b want 0 0 1", bus.res_valid, bus.busy, bus.cmd_ready); end
        @(negedge clk);
    endtask

    task automatic test_len0();
        bit to1, to2;
        for (int m = 0; m < 2; m++) begin
            start_job(m[0], 8'd0, m[0], to1);
            #1;
            checks++; if (bus.mac_instruction !== {m[0], 2'b00} || bus.mac_stall !== 1'b0 || bus.op_ready !== 1'b0) begin
                errors++; $display("FAIL len0_clear%0d: got ins=%b stall=%b opr=%b want %b 0 0", m, bus.mac_instruction, bus.mac_stall, bus.op_ready, {m[0], 2'b00});
            end
            wait_res(to2);
            checks++; if (to1 !== 1'b0 || to2 !== 1'b0 || bus.res_data !== 32'h0 || bus.res_guard !== 8'h0) begin
                errors++; $display("FAIL len0_result%0d: got %h/%h to=%b%b want 00000000/00", m, bus.res_data, bus.res_guard, to1, to2);
            end
            accept_res();
        end
    endtask

    task automatic test_reset_mid();
        bit to1, to2; int bad; int late;
        load_basic();
        start_job(1'b0, 8'd3, 1'b0, to1);
        bus.op_valid = 1'b1; bus.op_a = pa[0]; bus.op_b = pb[0];
        @(negedge clk);
        bus.op_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (bus.busy !== 1'b0 || bus.res_valid !== 1'b0 || bus.mac_stall !== 1'b1) begin
            errors++; $display("FAIL abort_state: got busy=%b valid=%b stall=%b want 0 0 1", bus.busy, bus.res_valid, bus.mac_stall);
        end
        late = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus.res_valid !== 1'b0) late++;
        end
        checks++; if (late !== 0) begin errors++; $display("FAIL abort_no_result: got %0d valid cycles want 0", late); end
        pa[0] = 16'd5; pb[0] = 16'd6;
        start_job(1'b0, 8'd1, 1'b0, to1);
        feed_ops(1'b0, 1, 0, bad);
        wait_res(to2);
        checks++; if ({to1, to2, bad != 0} !== 3'b000 || bus.res_data !== 32'h0000001E) begin
            errors++; $display("FAIL abort_next_job: got %h to=%b%b bad=%0d want 0000001E", bus.res_data, to1, to2, bad);
        end
        accept_res();
    endtask

    task automatic test_back_to_back_random();
        bit to1, to2; int bad; int len, gap; bit mode, sat;
        logic [39:0] exp;
        for (int j = 0; j < 25; j++) begin
            mode = 1'($urandom_range(0, 1));
            sat  = 1'($urandom_range(0, 1));
            len  = $urandom_range(0, 10);
            gap  = $urandom_range(0, 2);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 2) == 0) begin
                    pa[i] = ($urandom_range(0, 1) == 1) ? 16'h7FFF : 16'h8000;
                    pb[i] = ($urandom_range(0, 1) == 1) ? 16'h8000 : 16'h8080;
                end else begin
                    pa[i] = 16'($urandom);
                    pb[i] = 16'($urandom);
                end
            end
            exp = ref_result(mode, len, sat);
            start_job(mode, 8'(len), sat, to1);
            #1;
            checks++; if (bus.cmd_ready !== 1'b0 || bus.busy !== 1'b1) begin errors++; $display("FAIL rnd%0d_busy: got ready=%b busy=%b want 0 1", j, bus.cmd_ready, bus.busy); end
            feed_ops(mode, len, gap, bad);
            wait_res(to2);
            checks++; if ({to1, to2, bad != 0} !== 3'b000) begin errors++; $display("FAIL rnd%0d_flow: got to=%b%b bad=%0d want 00 0", j, to1, to2, bad); end
            checks++; if (bus.res_data !== exp[31:0] || bus.res_guard !== exp[39:32]) begin
                errors++; $display("FAIL rnd%0d_result: mode=%b len=%0d sat=%b got %h/%h want %h/%h", j, mode, len, sat, bus.res_data, bus.res_guard, exp[31:0], exp[39:32]);
            end
            accept_res();
        end
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_mode  = 1'b0;
        bus.cmd_len   = 8'd0;
        bus.cmd_sat   = 1'b0;
        bus.op_valid  = 1'b0;
        bus.op_a      = 16'h0;
        bus.op_b      = 16'h0;
        bus.res_ready = 1'b0;
        test_reset();
        test_basic();
        test_sat();
        test_dual();
        test_gap();
        test_hold();
        test_len0();
        test_reset_mid();
        test_back_to_back_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mac_seq.md
MAC_SEQ -- requirements
Module: mac_seq

Interface
REQ-001 SHALL have port clk, input, 1 bit: single rising-edge clock for all state.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have ports cmd_valid (input, 1) and cmd_ready (output, 1): job request handshake.
REQ-004 SHALL have port cmd_mode, input, 1 bit: 0 selects 16x16 mode, 1 selects dual 8x8 mode.
REQ-005 SHALL have port cmd_len, input, 8 bits: number of operand pairs in the job (0..255).
REQ-006 SHALL have port cmd_sat, input, 1 bit: 1 requests a saturate instruction after the last pair.
REQ-007 SHALL have ports op_valid (input, 1), op_ready (output, 1), op_a (input, 16) and op_b (input, 16): signed operand stream.
REQ-008 SHALL have ports mac_instruction (output, 3), mac_multiplier (output, 16), mac_multiplicand (output, 16) and mac_stall (output, 1): drive the MAC.
REQ-009 SHALL have ports mac_result (input, 32) and mac_protect (input, 8): MAC accumulator and guard bits.
REQ-010 SHALL have ports res_valid (output, 1), res_ready (input, 1), res_data (output, 32) and res_guard (output, 8): result handshake.
REQ-011 SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-012 SHALL implement the FSM IDLE -> ISSUE -> (SAT) -> DRAIN -> CAPT -> OUT -> IDLE.
REQ-013 SHALL drive cmd_ready=1 only in IDLE; on cmd_valid&cmd_ready it SHALL latch mode, len and sat, clear the pair counter, and enter ISSUE.
REQ-014 SHALL, in ISSUE with len>0, drive op_ready=1, mac_stall=!op_valid, mac_multiplier=op_a and mac_multiplicand=op_b combinationally.
REQ-015 SHALL issue a pair on op_valid&op_ready: load (001 / dual 101) for the first pair, accumulate (010 / dual 110) for later pairs; the counter increments per issued pair.
REQ-016 SHALL never use instruction 000 as a bubble while data is in flight; an operand gap SHALL be covered only by mac_stall=1.
REQ-017 SHALL, after the pair counter reaches len, go to SAT if sat=1, otherwise to DRAIN.
REQ-018 SHALL, for len=0, issue one clear instruction (000 / dual 100) with mac_stall=0 and then go to SAT or DRAIN, giving res_data=0.
REQ-019 SHALL, in SAT, issue 011 (dual 111) for exactly one cycle with mac_stall=0 and op_ready=0.
REQ-020 SHALL, in DRAIN, hold mac_stall=0 and mac_instruction=000 for exactly 2 cycles (MAC latency is 3 unstalled edges, counting the issue edge).
REQ-021 SHALL, in CAPT, hold mac_stall=1 for 1 cycle and register mac_result into res_data and mac_protect into res_guard at the end of that cycle.
REQ-022 SHALL, in OUT, hold res_valid=1 with res_data and res_guard stable until res_ready, then return to IDLE with res_valid=0 on the next cycle.
REQ-023 SHALL drive mac_stall=1 and mac_instruction=000 in IDLE, CAPT and OUT, and op_ready=0 outside ISSUE.
REQ-024 SHALL treat operands as signed 16-bit; in dual mode byte [7:0] pairs with [7:0] and [15:8] with [15:8] inside the MAC, and the sequencer passes words unmodified.
REQ-025 SHALL pass res_guard unmodified, including after saturation.
REQ-026 SHALL ignore cmd_valid while busy=1; back-to-back jobs SHALL have at least one IDLE cycle between them.

Reset
REQ-027 SHALL, on reset=1 at a clock edge and regardless of state, go to IDLE and set res_valid=0, res_data=0, res_guard=0, the pair counter to 0, busy=0, cmd_ready=1, op_ready=0, mac_stall=1 and mac_instruction=000.
REQ-028 SHALL let reset take priority over every handshake in the same cycle; a job aborted by reset produces no result.

Verification
REQ-029 SHALL cover: mode0, len3, sat0, pairs (3,4),(-2,5),(100,100) -> res_data=0x00002712, res_guard=0x00.
REQ-030 SHALL cover: mode0, len3, pairs (0x7FFF,0x7FFF) x3 -> sat0 gives res_data=0xBFFD0003, guard 0x00; sat1 gives res_data=0x7FFFFFFF.
REQ-031 SHALL cover: mode1, len2, pairs (0x0203,0x0405) x2 -> res_data=0x0010001E, res_guard=0x00.
REQ-032 SHALL cover: the REQ-029 job with op_valid low for 2 cycles between each pair -> mac_stall=1 in exactly those cycles and an identical result.
REQ-033 SHALL cover: res_ready low for 5 cycles in OUT -> res_valid held at 1, res_data stable, cmd_ready=0, then handoff on res_ready.
REQ-034 SHALL cover: reset asserted mid-ISSUE after 1 of 3 pairs -> next cycle busy=0, res_valid=0, mac_stall=1, and a new len1 job (5,6) yields 0x0000001E.
